irq_prio_controller: RTL and testbench
======================================

// Module: irq_prio_controller
// PURPOSE
//  Parametrised machine-mode interrupt controller sitting between peripheral IRQ lines and the core CSR/trap unit.
//  Selects the highest-priority enabled pending source in one cycle and latches its ID.
//  Raises INT_o until the core takes the trap, then holds the ID until mret (INT_RST_i).
//  Pulses the one-hot completion on int_fin_o. Supersedes the scanning-counter controller: no scan latency, N sources.
// PARAMETERS
//  NUM_IRQ  8                          number of sources, 2..32; source 0 = highest priority
//  ID_W     $clog2(NUM_IRQ)            width of the source ID (localparam, not overridable)
// PORTS
//  clk_i      in   1        clock, all state on posedge
//  rst_i      in   1        asynchronous active-high reset
//  int_req_i  in   NUM_IRQ  raw interrupt requests from peripherals
//  mie_i      in   NUM_IRQ  per-source enable (mie CSR slice)
//  int_ack_i  in   1        core entered the trap handler for the presented interrupt (1-cycle pulse)
//  INT_RST_i  in   1        core executed mret; current interrupt is complete (1-cycle pulse)
//  INT_o      out  1        interrupt request to core, level, high only in state PEND
//  int_fin_o  out  NUM_IRQ  one-hot completion pulse to the serviced peripheral, 1 cycle
//  mcause_o   out  32       {1'b1, zeros, id_q}; valid in PEND and SERV
// BEHAVIOUR
//  Reset: state=IDLE, id_q=0, pend_q=0, INT_o=0, int_fin_o=0, mcause_o=32'h8000_0000.
//  Candidate vector: cand = pend & mie_i.
//   - pend = int_req_i (level mode) or pend_q (edge mode).
//   - Selection is the lowest set index of cand, combinational.
//  FSM (registered state, from the package enum):
//   IDLE: if |cand, then id_q<=sel_id and go to PEND next cycle. INT_o rises 1 cycle after the request is seen.
//   PEND: INT_o=1.
//    - int_ack_i: go to SERV.
//    - else if cand[id_q]==0 (request dropped or mie cleared): withdraw to IDLE, INT_o falls next cycle, no int_fin_o.
//    - id_q is NOT re-arbitrated in PEND. A higher-priority arrival waits for the next IDLE.
//    - INT_RST_i in PEND is ignored.
//   SERV: INT_o=0; int_ack_i ignored.
//    - On INT_RST_i: int_fin_o[id_q]=1 for exactly that cycle (combinational from state & INT_RST_i), then go to IDLE.
//    - Source changes in SERV do not affect id_q or mcause_o.
//  Simultaneous int_ack_i and withdrawal condition in PEND: ack wins (SERV).
//  Back-to-back: a source still pending after IDLE re-enters PEND on the cycle after IDLE, so the INT_o gap is >=1 cycle.
//  NUM_IRQ<32: mcause_o bits [30:ID_W] are zero. Inputs above NUM_IRQ do not exist.
//  rst_i mid-operation: immediate return to reset values. An in-flight completion is dropped (no int_fin_o).
// CONFIGURATION
//  IRQ_CTRL_EDGE_EN defined: edge-triggered capture.
//   - req_d_q samples int_req_i each cycle.
//   - pend_q[i] sets on int_req_i[i] & ~req_d_q[i], independent of mie_i.
//   - pend_q[i] clears in the cycle int_fin_o[i]=1; set beats clear in the same cycle.
//   - Withdrawal in PEND happens only via mie_i.
//  IRQ_CTRL_EDGE_EN undefined: level-sensitive, pend = int_req_i.
//   - No pend_q/req_d_q flops (reset values are then n/a).
//   - Peripheral must hold the request until int_fin_o.
// STRUCTURE
//  Package irq_ctrl_pkg:
//   - typedef enum logic [1:0] {IRQ_IDLE, IRQ_PEND, IRQ_SERV} irq_state_e;
//   - MCAUSE_INT_BIT = 31; IRQ_MAX_NUM = 32.
//  Sub-module irq_prio_enc #(N): cand[N] -> valid, id[$clog2(N)], lowest-index-wins, purely combinational.
// TESTING (NUM_IRQ=8)
//  1 Reset: rst_i=1 with int_req_i=8'hFF, mie_i=8'hFF.
//    -> INT_o=0, int_fin_o=0, mcause_o=32'h8000_0000 throughout reset.
//  2 Priority: mie_i=8'hFF, int_req_i=8'b0010_1000 at cycle t.
//    -> INT_o=1 at t+1, mcause_o=32'h8000_0003.
//    Then int_ack_i, INT_RST_i -> int_fin_o=8'h08 for 1 cycle; next PEND shows mcause_o=32'h8000_0005.
//  3 Masking/withdraw: int_req_i=8'h04, mie_i=8'h00 -> INT_o stays 0.
//    Set mie_i=8'h04 -> INT_o=1; clear mie_i before ack -> INT_o=0 next cycle, int_fin_o never asserts.
//  4 No preemption: in SERV with id 6, raise int_req_i[0].
//    -> mcause_o stays 32'h8000_0006 until INT_RST_i; then PEND with id 0.
//  5 Edge mode (IRQ_CTRL_EDGE_EN): 1-cycle pulse on int_req_i[2].
//    -> pend_q[2] latched, INT_o=1, full service completes.
//    Second pulse on the same cycle as int_fin_o[2] -> pend_q[2] stays set, re-serviced.
//  6 Reset in SERV: assert rst_i between int_ack_i and INT_RST_i.
//    -> state IDLE, int_fin_o stays 0, re-arbitration after release.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl_pkg
//  Description : Shared types and constants for the priority interrupt
//                controller (FSM state encoding, mcause layout, size limit).
//  Revision    : 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_PEND = 2'd1,
        IRQ_SERV = 2'd2
    } irq_state_e;

    // mcause bit flagging an asynchronous (interrupt) cause
    localparam int MCAUSE_INT_BIT = 31;
    // Largest number of sources the mcause ID field can describe
    localparam int IRQ_MAX_NUM    = 32;

endpackage : irq_ctrl_pkg
`default_nettype wire

// File: rtl/irq_prio_controller_enc.sv
`default_nettype none
// ============================================================================
//  Module      : irq_prio_enc
//  Description : Fixed-priority encoder. Reports whether any candidate bit is
//                set and the index of the lowest set bit (index 0 wins).
//                Purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0]         cand,
    output logic                 valid,
    output logic [$clog2(N)-1:0] id
);

    localparam int W = $clog2(N);

    // Walk from the top index down so the lowest set index is the last write
    always_comb begin
        valid = |cand;
        id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) begin
                id = W'(i);
            end
        end
    end

endmodule : irq_prio_enc
`default_nettype wire

// File: rtl/irq_prio_controller.sv
`default_nettype none
// ============================================================================
//  Module      : irq_prio_controller
//  Description : Machine-mode interrupt controller. Picks the highest-priority
//                enabled pending source in one cycle, raises INT_o until the
//                core takes the trap, holds the ID until mret and then pulses
//                a one-hot completion back to the serviced peripheral.
//  Config      : IRQ_CTRL_EDGE_EN - when defined, requests are edge-captured
//                into a pending register; otherwise they are level-sensitive.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_controller
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_IRQ-1:0] int_req_i,
    input  logic [NUM_IRQ-1:0] mie_i,
    input  logic               int_ack_i,
    input  logic               INT_RST_i,
    output logic               INT_o,
    output logic [NUM_IRQ-1:0] int_fin_o,
    output logic [31:0]        mcause_o
);

    localparam int ID_W = $clog2(NUM_IRQ);

    // Reject configurations the mcause ID field cannot represent
    if (NUM_IRQ < 2 || NUM_IRQ > IRQ_MAX_NUM) begin : g_bad_num_irq
        $error("irq_prio_controller: NUM_IRQ must be in 2..32");
    end

    irq_state_e         r_state;
    irq_state_e         w_state_nxt;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    w_sel_id;
    logic               w_sel_vld;
    logic [NUM_IRQ-1:0] w_pend;
    logic [NUM_IRQ-1:0] w_cand;
    logic [NUM_IRQ-1:0] w_fin;
    logic               w_int;
    logic [31:0]        w_mcause;

`ifdef IRQ_CTRL_EDGE_EN
    logic [NUM_IRQ-1:0] r_pend;
    logic [NUM_IRQ-1:0] r_req_d;

    // Capture rising edges; a new edge outranks the completion clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_req_d <= '0;
            r_pend  <= '0;
        end else begin
            r_req_d <= int_req_i;
            r_pend  <= (r_pend & ~w_fin) | (int_req_i & ~r_req_d);
        end
    end

    assign w_pend = r_pend;
`else
    // Level mode: the peripheral holds its request until completion
    assign w_pend = int_req_i;
`endif

    assign w_cand = w_pend & mie_i;

    irq_prio_enc #(
        .N (NUM_IRQ)
    ) u_enc (
        .cand  (w_cand),
        .valid (w_sel_vld),
        .id    (w_sel_id)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IRQ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the winning ID only when leaving IDLE; no re-arbitration later
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_id <= '0;
        end else if (r_state == IRQ_IDLE && w_sel_vld) begin
            r_id <= w_sel_id;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_int       = 1'b0;
        w_fin       = '0;
        case (r_state)
            IRQ_IDLE: begin
                if (w_sel_vld) begin
                    w_state_nxt = IRQ_PEND;
                end
            end
            IRQ_PEND: begin
                w_int = 1'b1;
                // Acknowledge wins over a simultaneous withdrawal
                if (int_ack_i) begin
                    w_state_nxt = IRQ_SERV;
                end else if (!w_cand[r_id]) begin
                    w_state_nxt = IRQ_IDLE;
                end
            end
            IRQ_SERV: begin
                if (INT_RST_i) begin
                    w_fin[r_id] = 1'b1;
                    w_state_nxt = IRQ_IDLE;
                end
            end
            default: begin
                w_state_nxt = IRQ_IDLE;
            end
        endcase
    end

    // mcause: interrupt flag plus zero-extended source ID
    always_comb begin
        w_mcause                 = '0;
        w_mcause[MCAUSE_INT_BIT] = 1'b1;
        w_mcause[ID_W-1:0]       = r_id;
    end

    assign INT_o     = w_int;
    assign int_fin_o = w_fin;
    assign mcause_o  = w_mcause;

endmodule : irq_prio_controller
`default_nettype wire

// File: tb/tb_irq_prio_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_prio_controller
//  Description : Self-checking bench for irq_prio_controller (NUM_IRQ = 8).
//                Each step drives inputs and queues the outputs expected in
//                that cycle; a negedge monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_prio_controller;

    logic        clk_i;
    logic        rst_i;
    logic [7:0]  int_req_i;
    logic [7:0]  mie_i;
    logic        int_ack_i;
    logic        INT_RST_i;
    logic        INT_o;
    logic [7:0]  int_fin_o;
    logic [31:0] mcause_o;

    typedef struct {
        logic        int_o;
        logic [7:0]  fin;
        logic [31:0] cause;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    irq_prio_controller #(
        .NUM_IRQ (8)
    ) u_dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .int_req_i (int_req_i),
        .mie_i     (mie_i),
        .int_ack_i (int_ack_i),
        .INT_RST_i (INT_RST_i),
        .INT_o     (INT_o),
        .int_fin_o (int_fin_o),
        .mcause_o  (mcause_o)
    );

    // Start high so the first negedge precedes the first posedge
    initial begin
        clk_i = 1'b1;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mc(input int id);
        return 32'h8000_0000 | 32'(id);
    endfunction

    // Scoreboard consumer: outputs are stable mid-cycle
    always @(negedge clk_i) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, ".INT_o"},     {31'd0, INT_o},     {31'd0, e.int_o});
            check({e.tag, ".int_fin_o"}, {24'd0, int_fin_o}, {24'd0, e.fin});
            check({e.tag, ".mcause_o"},  mcause_o,           e.cause);
        end
    end

    // Drive one cycle of stimulus and queue the outputs expected in it
    task automatic step(input logic r, input logic [7:0] req, input logic [7:0] mie,
                        input logic ack, input logic mret,
                        input logic ei, input logic [7:0] ef, input logic [31:0] ec,
                        input string tag);
        exp_t e;
        rst_i     = r;
        int_req_i = req;
        mie_i     = mie;
        int_ack_i = ack;
        INT_RST_i = mret;
        e.int_o   = ei;
        e.fin     = ef;
        e.cause   = ec;
        e.tag     = tag;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset with everything requested and enabled, even ack/mret pulses
        step(1, 8'hFF, 8'hFF, 0, 0, 0, 8'h00, mc(0), "t1_rst0");
        step(1, 8'hFF, 8'hFF, 1, 1, 0, 8'h00, mc(0), "t1_rst1");
        step(1, 8'hFF, 8'hFF, 0, 0, 0, 8'h00, mc(0), "t1_rst2");
        step(1, 8'h00, 8'hFF, 0, 0, 0, 8'h00, mc(0), "t1_rst3");
        step(0, 8'h00, 8'hFF, 0, 0, 0, 8'h00, mc(0), "t1_idle");

`ifdef IRQ_CTRL_EDGE_EN
        // Single pulse on source 2, then a re-pulse coinciding with completion
        step(0, 8'h04, 8'hFF, 0, 0, 0, 8'h00, mc(0), "t5_pulse");
        step(0, 8'h00, 8'hFF, 0, 0, 0, 8'h00, mc(0), "t5_latched");
        step(0, 8'h00, 8'hFF, 1, 0, 1, 8'h00, mc(2), "t5_pend");
        step(0, 8'h04, 8'hFF, 0, 1, 0, 8'h04, mc(2), "t5_fin_repulse");
        step(0, 8'h00, 8'hFF, 0, 0, 0, 8'h00, mc(2), "t5_gap");
        step(0, 8'h00, 8'hFF, 1, 0, 1, 8'h00, mc(2), "t5_repend");
        step(0, 8'h00, 8'hFF, 0, 1, 0, 8'h04, mc(2), "t5_fin2");
        step(0, 8'h00, 8'hFF, 0, 0, 0, 8'h00, mc(2), "t5_idle");
        step(0, 8'h00, 8'hFF, 0, 0, 0, 8'h00, mc(2), "t5_idle2");
`else
        // Priority: sources 3 and 5 together, 3 served first, then 5
        step(0, 8'h28, 8'hFF, 0, 0, 0, 8'h00, mc(0), "t2_see");
        step(0, 8'h28, 8'hFF, 1, 0, 1, 8'h00, mc(3), "t2_pend3");
        step(0, 8'h28, 8'hFF, 0, 1, 0, 8'h08, mc(3), "t2_fin3");
        step(0, 8'h20, 8'hFF, 0, 0, 0, 8'h00, mc(3), "t2_gap");
        step(0, 8'h20, 8'hFF, 1, 0, 1, 8'h00, mc(5), "t2_pend5");
        step(0, 8'h20, 8'hFF, 0, 1, 0, 8'h20, mc(5), "t2_fin5");
        step(0, 8'h00, 8'hFF, 0, 0, 0, 8'h00, mc(5), "t2_idle");

        // Masking and withdrawal before acknowledge
        step(0, 8'h04, 8'h00, 0, 0, 0, 8'h00, mc(5), "t3_mask");
        step(0, 8'h04, 8'h00, 0, 0, 0, 8'h00, mc(5), "t3_mask2");
        step(0, 8'h04, 8'h04, 0, 0, 0, 8'h00, mc(5), "t3_en");
        step(0, 8'h04, 8'h00, 0, 0, 1, 8'h00, mc(2), "t3_pend2");
        step(0, 8'h04, 8'h00, 0, 0, 0, 8'h00, mc(2), "t3_wd");
        step(0, 8'h00, 8'h00, 0, 0, 0, 8'h00, mc(2), "t3_wd2");

        // Acknowledge and withdrawal in the same cycle: acknowledge wins
        step(0, 8'h02, 8'hFF, 0, 0, 0, 8'h00, mc(2), "t3b_see");
        step(0, 8'h02, 8'h00, 1, 0, 1, 8'h00, mc(1), "t3b_pend");
        step(0, 8'h02, 8'h00, 0, 1, 0, 8'h02, mc(1), "t3b_fin");
        step(0, 8'h00, 8'hFF, 0, 0, 0, 8'h00, mc(1), "t3b_idle");

        // No preemption while serving source 6; mret ignored in PEND
        step(0, 8'h40, 8'hFF, 0, 0, 0, 8'h00, mc(1), "t4_see");
        step(0, 8'h40, 8'hFF, 0, 1, 1, 8'h00, mc(6), "t4_pend_mret");
        step(0, 8'h40, 8'hFF, 1, 0, 1, 8'h00, mc(6), "t4_pend_ack");
        step(0, 8'h41, 8'hFF, 0, 0, 0, 8'h00, mc(6), "t4_serv");
        step(0, 8'h41, 8'hFF, 1, 0, 0, 8'h00, mc(6), "t4_serv_ack");
        step(0, 8'h41, 8'hFF, 0, 1, 0, 8'h40, mc(6), "t4_fin6");
        step(0, 8'h01, 8'hFF, 0, 0, 0, 8'h00, mc(6), "t4_gap");
        step(0, 8'h01, 8'hFF, 1, 0, 1, 8'h00, mc(0), "t4_pend0");
        step(0, 8'h01, 8'hFF, 0, 1, 0, 8'h01, mc(0), "t4_fin0");
        step(0, 8'h00, 8'hFF, 0, 0, 0, 8'h00, mc(0), "t4_idle");

        // Reset while serving drops the completion, then re-arbitrates
        step(0, 8'h10, 8'hFF, 0, 0, 0, 8'h00, mc(0), "t6_see");
        step(0, 8'h10, 8'hFF, 1, 0, 1, 8'h00, mc(4), "t6_pend");
        step(0, 8'h10, 8'hFF, 0, 0, 0, 8'h00, mc(4), "t6_serv");
        step(1, 8'h10, 8'hFF, 0, 1, 0, 8'h00, mc(0), "t6_rst");
        step(0, 8'h10, 8'hFF, 0, 0, 0, 8'h00, mc(0), "t6_rel");
        step(0, 8'h10, 8'hFF, 1, 0, 1, 8'h00, mc(4), "t6_rearb");
        step(0, 8'h10, 8'hFF, 0, 1, 0, 8'h10, mc(4), "t6_fin");
        step(0, 8'h00, 8'hFF, 0, 0, 0, 8'h00, mc(4), "t6_idle");
`endif

        @(negedge clk_i);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_irq_prio_controller
`default_nettype wire
